// File: rtl/id_stage_fwdn.sv
// ============================================================================
// Module   : id_stage_fwdn
// Brief    : RV32I decode stage with NUM_FWD-source priority bypass, branch
//            resolution, flush, load-use stall and illegal-opcode flag.
//            Optional performance counters: define ID_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_fwdn #(
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_inst,
    input  logic [NUM_FWD-1:0]      fwd_addr_vld,
    input  logic [NUM_FWD-1:0]      fwd_data_vld,
    input  logic [NUM_FWD*5-1:0]    fwd_addr,
    input  logic [NUM_FWD*32-1:0]   fwd_data,
    output logic [4:0]              rf_raddr1,
    output logic [4:0]              rf_raddr2,
    input  logic [31:0]             rf_rdata1,
    input  logic [31:0]             rf_rdata2,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_rs1_val,
    output logic [31:0]             out_rs2_val,
    output logic [31:0]             out_imm,
    output logic [21:0]             out_ctrl,
    output logic                    br_taken,
    output logic [31:0]             br_target,
    output logic [CNT_W-1:0]        perf_stall,
    output logic [CNT_W-1:0]        perf_redirect
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [2:0] c_ALU_ADD = 3'd0, c_ALU_SUB = 3'd1, c_ALU_SLT = 3'd2, c_ALU_SLTU = 3'd3;
    localparam logic [2:0] c_ALU_XOR = 3'd4, c_ALU_OR  = 3'd5, c_ALU_AND = 3'd6, c_ALU_SHF  = 3'd7;
    localparam logic [1:0] c_SHF_SLL = 2'd0, c_SHF_SRL = 2'd1, c_SHF_SRA = 2'd2;
    localparam logic [2:0] c_WB_ALU  = 3'd0, c_WB_MEM  = 3'd1, c_WB_PC4  = 3'd2, c_WB_IMM   = 3'd3;

    logic        r_id_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic        w_is_jal, w_is_jalr, w_is_branch, w_is_load, w_is_store, w_is_opimm, w_is_op;
    logic        w_is_lui, w_is_auipc, w_illegal, w_use1, w_use2, w_ready_go, w_cond, w_take;
    logic        w_hit1, w_hit2, w_dvld1, w_dvld2;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [2:0]  w_alu_op, w_wb_src;
    logic [1:0]  w_shift_op;
    logic        w_rf_we;

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_funct3 = r_inst[14:12];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];

    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_auipc  = (w_opcode == c_OP_AUIPC);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_is_jalr   = (w_opcode == c_OP_JALR);
    assign w_is_branch = (w_opcode == c_OP_BRANCH);
    assign w_is_load   = (w_opcode == c_OP_LOAD);
    assign w_is_store  = (w_opcode == c_OP_STORE);
    assign w_is_opimm  = (w_opcode == c_OP_IMM);
    assign w_is_op     = (w_opcode == c_OP_REG);
    assign w_illegal   = !(w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                           w_is_load | w_is_store | w_is_opimm | w_is_op);

    assign w_use1 = w_is_jalr | w_is_branch | w_is_load | w_is_store | w_is_opimm | w_is_op;
    assign w_use2 = w_is_branch | w_is_store | w_is_op;

    assign rf_raddr1 = w_rs1;
    assign rf_raddr2 = w_rs2;

    // Scan from oldest to youngest so the lowest matching index overwrites last.
    always_comb begin
        w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : rf_rdata1;
        w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : rf_rdata2;
        w_hit1 = 1'b0; w_dvld1 = 1'b1;
        w_hit2 = 1'b0; w_dvld2 = 1'b1;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_rs1 != 5'd0 && fwd_addr_vld[i] && fwd_addr[5*i +: 5] == w_rs1) begin
                w_rs1_val = fwd_data[32*i +: 32];
                w_hit1    = 1'b1;
                w_dvld1   = fwd_data_vld[i];
            end
            if (w_rs2 != 5'd0 && fwd_addr_vld[i] && fwd_addr[5*i +: 5] == w_rs2) begin
                w_rs2_val = fwd_data[32*i +: 32];
                w_hit2    = 1'b1;
                w_dvld2   = fwd_data_vld[i];
            end
        end
    end

    assign w_ready_go = !(w_use1 && w_hit1 && !w_dvld1) && !(w_use2 && w_hit2 && !w_dvld2);

    assign in_ready  = !flush && (!r_id_valid || (w_ready_go && out_ready));
    assign out_valid = r_id_valid && w_ready_go && !flush;

    always_comb begin
        case (w_funct3)
            3'b000:  w_cond = (w_rs1_val == w_rs2_val);
            3'b001:  w_cond = (w_rs1_val != w_rs2_val);
            3'b100:  w_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_cond = (w_rs1_val <  w_rs2_val);
            3'b111:  w_cond = (w_rs1_val >= w_rs2_val);
            default: w_cond = 1'b0;
        endcase
    end

    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    assign w_imm_i = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_imm_s = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
    assign w_imm_b = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_imm_u = {r_inst[31:12], 12'd0};
    assign w_imm_j = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

    assign w_take   = w_is_jal | w_is_jalr | (w_is_branch & w_cond);
    assign br_taken = r_id_valid && w_ready_go && out_ready && !flush && w_take;

    always_comb begin
        if (w_is_jal)                  br_target = r_pc + w_imm_j;
        else if (w_is_jalr)            br_target = (w_rs1_val + w_imm_i) & ~32'd1;
        else if (w_is_branch && w_cond) br_target = r_pc + w_imm_b;
        else                           br_target = r_pc + 32'd4;
    end

    always_comb begin
        w_alu_op   = c_ALU_ADD;
        w_shift_op = c_SHF_SLL;
        w_wb_src   = c_WB_ALU;
        out_imm    = 32'd0;
        case (w_opcode)
            c_OP_LUI:    begin out_imm = w_imm_u; w_wb_src = c_WB_IMM; end
            c_OP_AUIPC:  out_imm = w_imm_u;
            c_OP_JAL:    begin out_imm = w_imm_j; w_wb_src = c_WB_PC4; end
            c_OP_JALR:   begin out_imm = w_imm_i; w_wb_src = c_WB_PC4; end
            c_OP_BRANCH: out_imm = w_imm_b;
            c_OP_LOAD:   begin out_imm = w_imm_i; w_wb_src = c_WB_MEM; end
            c_OP_STORE:  out_imm = w_imm_s;
            c_OP_IMM, c_OP_REG: begin
                out_imm = w_imm_i;
                case (w_funct3)
                    3'b000: w_alu_op = (w_is_op && r_inst[30]) ? c_ALU_SUB : c_ALU_ADD;
                    3'b001: begin w_alu_op = c_ALU_SHF; w_shift_op = c_SHF_SLL; end
                    3'b010: w_alu_op = c_ALU_SLT;
                    3'b011: w_alu_op = c_ALU_SLTU;
                    3'b100: w_alu_op = c_ALU_XOR;
                    3'b101: begin w_alu_op = c_ALU_SHF; w_shift_op = r_inst[30] ? c_SHF_SRA : c_SHF_SRL; end
                    3'b110: w_alu_op = c_ALU_OR;
                    default: w_alu_op = c_ALU_AND;
                endcase
                // Immediate shifts carry a 5-bit shamt, not a signed immediate.
                if (w_is_opimm && (w_funct3 == 3'b001 || w_funct3 == 3'b101))
                    out_imm = {27'd0, r_inst[24:20]};
                else if (w_is_op)
                    out_imm = 32'd0;
            end
            default: ;
        endcase
    end

    assign w_rf_we = (w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_load | w_is_opimm | w_is_op)
                     && (w_rd != 5'd0);

    assign out_ctrl = {w_alu_op, w_shift_op, w_rf_we, w_rd, w_wb_src, w_is_load, w_is_store,
                       w_funct3, w_illegal, 2'b00};
    assign out_pc      = r_pc;
    assign out_rs1_val = w_rs1_val;
    assign out_rs2_val = w_rs2_val;

    // Flush beats redirect, redirect drops the wrong-path fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id_valid <= 1'b0;
        end else if (flush || br_taken) begin
            r_id_valid <= 1'b0;
        end else if (in_ready) begin
            r_id_valid <= in_valid;
            if (in_valid) begin
                r_pc   <= in_pc;
                r_inst <= in_inst;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (r_id_valid && !w_ready_go && !flush && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (br_taken && r_perf_redirect != '1)
                r_perf_redirect <= r_perf_redirect + 1'b1;
        end
    end

    assign perf_stall    = r_perf_stall;
    assign perf_redirect = r_perf_redirect;
`else
    assign perf_stall    = '0;
    assign perf_redirect = '0;
`endif

endmodule

`default_nettype wire
